// File: rtl/cla_pkg.sv
// Shared types and configuration constants for the pipelined carry-lookahead adder.
package cla_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    localparam logic STAGE_EMPTY = 1'b0;
    localparam logic STAGE_FULL  = 1'b1;

    // Legal only when the operand splits evenly into STAGES segments of whole blocks.
    function automatic bit cfg_legal(input int width, input int blk, input int stages);
        if (stages < 1 || blk < 1 || width < 1)
            return 1'b0;
        return (width % (stages * blk)) == 0;
    endfunction

endpackage

// File: rtl/pipe_cla_adder_if.sv
// Operand/result handshake bundle between a producer, the adder and its consumer.
interface pipe_cla_adder_if #(parameter int WIDTH = 32);
    import cla_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    op_t              op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );

endinterface

// File: rtl/pipe_cla_adder_cla_block.sv
// One BLK-bit carry-lookahead block: every carry is a flat sum of products of g/p/cin.
module cla_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout
);

    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic term;
        c    = '0;
        term = 1'b0;
        c[0] = cin;
        for (int i = 0; i < BLK; i++) begin
            c[i+1] = g[i];
            term = cin;
            for (int m = 0; m <= i; m++)
                term = term & p[m];
            c[i+1] = c[i+1] | term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++)
                    term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
    end

    assign s    = p ^ c[BLK-1:0];
    assign cout = c[BLK];

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined add/subtract: one WIDTH/STAGES-bit segment per stage, valid/ready flow control.
module pipe_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BLK    = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_cla_adder_if.slave  bus
);

    localparam int SEG      = WIDTH / STAGES;
    localparam int NBLK     = WIDTH / BLK;
    localparam int SEG_BLKS = SEG / BLK;
    localparam int LAST     = STAGES - 1;

    if (!cfg_legal(WIDTH, BLK, STAGES)) begin : g_bad_cfg
        $error("pipe_cla_adder: WIDTH must be a multiple of STAGES*BLK and STAGES >= 1");
    end

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  s_q   [STAGES];
    logic              ovf_q;
    logic              zero_q;

    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];
    logic [WIDTH-1:0]  nxt_s [STAGES];
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] seg_cout;
    logic [WIDTH-1:0]  blk_sum;
    logic              ovf_d;
    logic              zero_d;

    // Ready ripples backwards from out_ready through the stage valids only.
    always_comb begin
        logic rdy;
        adv  = '0;
        load = '0;
        rdy  = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k]  = v_q[k] & rdy;
            load[k] = ~v_q[k] | adv[k];
            rdy     = load[k];
        end
    end

    assign bus.in_ready = load[0];

    // Subtraction folds into addition here so later stages never see op.
    always_comb begin
        v_in[0]  = bus.in_valid;
        src_a[0] = bus.a;
        src_b[0] = (bus.op == OP_SUB) ? ~bus.b : bus.b;
        src_s[0] = '0;
        src_c[0] = (bus.op == OP_SUB) ? 1'b1 : bus.cin;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k]  = v_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
        end
    end

    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        localparam int K = i / SEG_BLKS;
        logic           ci;
        logic           co;
        logic [BLK-1:0] sum;

        if (i % SEG_BLKS == 0) begin : g_seg_first
            assign ci = src_c[K];
        end else begin : g_seg_chain
            assign ci = g_blk[i-1].co;
        end

        if (i % SEG_BLKS == SEG_BLKS - 1) begin : g_seg_last
            assign seg_cout[K] = co;
        end

        cla_block #(.BLK(BLK)) u_blk (
            .a    (src_a[K][i*BLK +: BLK]),
            .b    (src_b[K][i*BLK +: BLK]),
            .cin  (ci),
            .s    (sum),
            .cout (co)
        );

        assign blk_sum[i*BLK +: BLK] = sum;
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_s[k] = src_s[k];
            nxt_s[k][k*SEG +: SEG] = blk_sum[k*SEG +: SEG];
        end
    end

    assign ovf_d  = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
                    (nxt_s[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
    assign zero_d = (nxt_s[LAST] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= {STAGES{STAGE_EMPTY}};
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    v_q[k] <= v_in[k];
                    if (v_in[k]) begin
                        a_q[k] <= src_a[k];
                        b_q[k] <= src_b[k];
                        s_q[k] <= nxt_s[k];
                        c_q[k] <= seg_cout[k];
                    end
                end
            end
            if (load[LAST] && v_in[LAST]) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign bus.out_valid = v_q[LAST];
    assign bus.s         = s_q[LAST];
    assign bus.cout      = c_q[LAST];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Directed and streaming checks for pipe_cla_adder at WIDTH=32, BLK=4, STAGES=2.
module tb_pipe_cla_adder;
    import cla_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    pipe_cla_adder_if #(.WIDTH(32)) bus();

    pipe_cla_adder #(.WIDTH(32), .BLK(4), .STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int check_cnt = 0;

    task automatic set_bundle(input logic v, input op_t o, input logic [31:0] av,
                              input logic [31:0] bv, input logic c);
        bus.in_valid = v;
        bus.op       = o;
        bus.a        = av;
        bus.b        = bv;
        bus.cin      = c;
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b1;
        set_bundle(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b0;
        #12;
        check_cnt++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, want 0/1", bus.out_valid, bus.in_ready);
        else pass_cnt++;
        check_cnt++;
        if ({bus.s, bus.cout, bus.ovf, bus.zero} !== 35'h0)
            $display("FAIL reset_data: s=%h cout=%b ovf=%b zero=%b, want all 0", bus.s, bus.cout, bus.ovf, bus.zero);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL after_reset: in_ready=%b out_valid=%b, want 1/0", bus.in_ready, bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_add_wrap();
        @(negedge clk);
        set_bundle(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        @(negedge clk);
        set_bundle(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
        check_cnt++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL wrap_latency1: out_valid=%b, want 0", bus.out_valid);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if ({bus.out_valid, bus.s, bus.cout, bus.zero, bus.ovf} !== {1'b1, 32'h0, 1'b1, 1'b1, 1'b0})
            $display("FAIL wrap_result: v=%b s=%h cout=%b zero=%b ovf=%b, want 1 00000000 1 1 0",
                     bus.out_valid, bus.s, bus.cout, bus.zero, bus.ovf);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL wrap_no_dup: out_valid=%b, want 0", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_vectors();
        op_t         t_op  [8] = '{OP_ADD, OP_SUB, OP_SUB, OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_SUB};
        logic [31:0] t_a   [8] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_000A, 32'hFFFF_FFFF,
                                   32'h0000_FFFF, 32'h8000_0000, 32'h0000_0005, 32'h0000_0000};
        logic [31:0] t_b   [8] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0003, 32'hFFFF_FFFF,
                                   32'h0000_0001, 32'h8000_0000, 32'h0000_0005, 32'h0000_0001};
        logic        t_cin [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] e_s   [8] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFF,
                                   32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        // flags are {cout, ovf, zero}
        logic [2:0]  e_f   [8] = '{3'b010, 3'b110, 3'b100, 3'b100, 3'b000, 3'b111, 3'b101, 3'b000};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check_cnt++;
                if (bus.out_valid !== 1'b1 || bus.s !== e_s[i-2])
                    $display("FAIL vec%0d_sum: v=%b s=%h, want 1 %h", i - 2, bus.out_valid, bus.s, e_s[i-2]);
                else pass_cnt++;
                check_cnt++;
                if ({bus.cout, bus.ovf, bus.zero} !== e_f[i-2])
                    $display("FAIL vec%0d_flags: cout/ovf/zero=%b, want %b", i - 2,
                             {bus.cout, bus.ovf, bus.zero}, e_f[i-2]);
                else pass_cnt++;
            end
            if (i < 8) set_bundle(1'b1, t_op[i], t_a[i], t_b[i], t_cin[i]);
            else       set_bundle(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus.out_ready = 1'b0;
        set_bundle(1'b1, OP_ADD, 32'd1, 32'd1, 1'b0);
        check_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_ready1: in_ready=%b, want 1", bus.in_ready);
        else pass_cnt++;
        @(negedge clk);
        set_bundle(1'b1, OP_ADD, 32'd2, 32'd2, 1'b0);
        check_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_ready2: in_ready=%b, want 1", bus.in_ready);
        else pass_cnt++;
        @(negedge clk);
        set_bundle(1'b1, OP_ADD, 32'd3, 32'd3, 1'b0);
        check_cnt++;
        if ({bus.in_ready, bus.out_valid, bus.s} !== {1'b0, 1'b1, 32'd2})
            $display("FAIL bp_full: in_ready=%b out_valid=%b s=%0d, want 0 1 2", bus.in_ready, bus.out_valid, bus.s);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if ({bus.in_ready, bus.out_valid, bus.s, bus.cout} !== {1'b0, 1'b1, 32'd2, 1'b0})
            $display("FAIL bp_hold: in_ready=%b out_valid=%b s=%0d cout=%b, want 0 1 2 0",
                     bus.in_ready, bus.out_valid, bus.s, bus.cout);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        #1;
        check_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: in_ready=%b, want 1", bus.in_ready);
        else pass_cnt++;
        @(negedge clk);
        set_bundle(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
        check_cnt++;
        if (bus.out_valid !== 1'b1 || bus.s !== 32'd4)
            $display("FAIL bp_second: out_valid=%b s=%0d, want 1 4", bus.out_valid, bus.s);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (bus.out_valid !== 1'b1 || bus.s !== 32'd6)
            $display("FAIL bp_third: out_valid=%b s=%0d, want 1 6", bus.out_valid, bus.s);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL bp_drained: out_valid=%b, want 0", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [33:0] exp_q[$];
        logic [33:0] e;
        logic [32:0] full;
        logic [31:0] av, bv, bb;
        logic        cv;
        op_t         ov;
        int          cyc  = 0;
        int          sent = 0;
        int          got  = 0;
        int          gaps = 0;
        bus.out_ready = 1'b1;
        while ((sent < 100 || exp_q.size() > 0) && cyc < 400) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_cnt++;
                    $display("FAIL stream_extra: unexpected result s=%h at cycle %0d", bus.s, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check_cnt++;
                    if ({bus.cout, bus.ovf, bus.zero, bus.s} !== {e[32], e[33], (e[31:0] == 32'h0), e[31:0]})
                        $display("FAIL stream_result%0d: cout/ovf/zero=%b s=%h, want %b %h", got,
                                 {bus.cout, bus.ovf, bus.zero}, bus.s,
                                 {e[32], e[33], (e[31:0] == 32'h0)}, e[31:0]);
                    else pass_cnt++;
                    got++;
                end
            end else if (cyc >= 2 && cyc < 102) begin
                gaps++;
            end
            if (sent < 100) begin
                av = $urandom();
                bv = $urandom();
                cv = 1'($urandom_range(0, 1));
                ov = op_t'($urandom_range(0, 1));
                set_bundle(1'b1, ov, av, bv, cv);
                if (bus.in_ready === 1'b1) begin
                    bb   = (ov == OP_SUB) ? ~bv : bv;
                    full = {1'b0, av} + {1'b0, bb} + ((ov == OP_SUB) ? 33'd1 : {32'd0, cv});
                    exp_q.push_back({(av[31] == bb[31]) && (full[31] != av[31]), full});
                    sent++;
                end
            end else begin
                set_bundle(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
            end
            cyc++;
        end
        check_cnt++;
        if (cyc >= 400 || got != 100)
            $display("FAIL stream_count: got %0d results in %0d cycles, want 100 within bound", got, cyc);
        else pass_cnt++;
        check_cnt++;
        if (gaps != 0) $display("FAIL stream_throughput: %0d bubble cycles, want 0", gaps);
        else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        bus.out_ready = 1'b1;
        @(negedge clk);
        set_bundle(1'b1, OP_ADD, 32'd100, 32'd200, 1'b0);
        @(negedge clk);
        set_bundle(1'b1, OP_ADD, 32'd7, 32'd8, 1'b0);
        @(negedge clk);
        set_bundle(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if (bus.out_valid !== 1'b0 || bus.s !== 32'h0 || bus.in_ready !== 1'b1)
            $display("FAIL midrst_clear: out_valid=%b s=%h in_ready=%b, want 0 0 1", bus.out_valid, bus.s, bus.in_ready);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_bundle(1'b1, OP_ADD, 32'd5, 32'd10, 1'b1);
        check_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL midrst_stale: out_valid=%b, want 0", bus.out_valid);
        else pass_cnt++;
        @(negedge clk);
        set_bundle(1'b0, OP_ADD, 32'h0, 32'h0, 1'b0);
        check_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL midrst_latency1: out_valid=%b, want 0", bus.out_valid);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (bus.out_valid !== 1'b1 || bus.s !== 32'd16 || bus.cout !== 1'b0)
            $display("FAIL midrst_result: out_valid=%b s=%0d cout=%b, want 1 16 0", bus.out_valid, bus.s, bus.cout);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL midrst_no_dup: out_valid=%b, want 0", bus.out_valid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_vectors();
        test_backpressure();
        test_stream();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 Parameter BLK, default 4: bits per carry-lookahead block.
REQ-003 Parameter STAGES, default 2: number of pipeline register stages; also the latency.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operand bundle valid.
REQ-007 in_ready  output  1  block accepts bundle this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in; used only for OP_ADD.
REQ-011 op  input  op_t  OP_ADD or OP_SUB.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 s  output  WIDTH  sum/difference.
REQ-015 cout  output  1  carry out of MSB.
REQ-016 ovf  output  1  signed two's-complement overflow.
REQ-017 zero  output  1  s == 0.

Function
REQ-018 OP_ADD SHALL compute {cout,s} = a + b + cin; OP_SUB SHALL compute {cout,s} = a + ~b + 1, ignoring cin.
REQ-019 ovf SHALL be 1 iff effective MSB operands (a, b or ~b) share a sign that differs from s[WIDTH-1].
REQ-020 Sum SHALL be split into STAGES equal segments, LSB segment first; each segment built from WIDTH/(STAGES*BLK) lookahead blocks, carry rippling block to block within a segment.
REQ-021 Segment carry-out SHALL be registered into the next stage; unprocessed upper operand bits and completed lower sum bits SHALL be carried forward in the stage registers.
REQ-022 Transfer in: occurs when in_valid && in_ready; transfer out: occurs when out_valid && out_ready.
REQ-023 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no stall; throughput one result per cycle.
REQ-024 Each stage register SHALL load when it is empty or the next stage advances in the same cycle; otherwise it SHALL hold its contents unchanged.
REQ-025 in_ready SHALL equal (stage 0 empty) or (stage 0 advancing); it SHALL be combinational from out_ready through the stage valids, with no combinational path from a, b, in_valid.
REQ-026 Full pipeline with out_ready=0: in_ready=0, all outputs stable until transfer out.
REQ-027 Simultaneous transfer out and transfer in on a full pipeline SHALL be accepted with no bubble and no loss.
REQ-028 Result order SHALL equal acceptance order; no result SHALL be dropped or duplicated.
REQ-029 s, cout, ovf, zero SHALL be valid only while out_valid=1 and SHALL not change while out_valid=1 and out_ready=0.

Reset
REQ-030 rst_n low SHALL asynchronously clear all stage valid bits; out_valid=0, s=0, cout=0, ovf=0, zero=0 (data registers cleared).
REQ-031 in_ready SHALL read 1 during and after reset (pipeline empty).
REQ-032 Reset mid-operation SHALL discard all in-flight bundles; the first post-reset accepted bundle SHALL emerge after STAGES cycles.

Structure
REQ-033 Package cla_pkg SHALL hold typedef op_t (OP_ADD=0, OP_SUB=1) and the stage-valid/legality constants.
REQ-034 Elaboration SHALL fail unless WIDTH % (STAGES*BLK) == 0 and STAGES >= 1.
REQ-035 Sub-module cla_block SHALL implement one BLK-bit lookahead block (generate/propagate, parallel carries, sum, carry-out); instantiated WIDTH/BLK times via generate.

Verification (WIDTH=32, BLK=4, STAGES=2)
REQ-036 ADD a=0xFFFFFFFF b=0x00000001 cin=0 -> 2 cycles later s=0x00000000 cout=1 zero=1 ovf=0.
REQ-037 ADD a=0x7FFFFFFF b=0x00000001 cin=0 -> s=0x80000000 ovf=1 cout=0; SUB a=0x80000000 b=0x00000001 -> s=0x7FFFFFFF ovf=1 cout=1.
REQ-038 out_ready=0, three back-to-back valid inputs (1+1, 2+2, 3+3) -> in_ready falls after two accepts; raise out_ready -> results 2, 4, 6 in order, none lost.
REQ-039 Continuous in_valid and out_ready=1 with 100 random bundles -> one result per cycle, all match reference model.
REQ-040 Assert rst_n low with two bundles in flight -> out_valid=0 immediately; after release, bundle 5+cin=1 of 10 -> s=16 after 2 cycles, no stale results.
